// File: rtl/multi38_2_if.sv
// Handshake bundle for multi38_2: carry-save pair input channel and resolved-result output channel.
interface multi38_2_if #(
  parameter int ACC_W = 46
);
  logic             in_valid;
  logic             in_ready;
  logic [37:0]      cout3;
  logic [37:0]      mulout3;
  logic             in_first;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;

  modport master (
    output in_valid, cout3, mulout3, in_first, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, cout3, mulout3, in_first, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/multi38_2.sv
// Two-stage carry-propagate resolver for the 31x8 carry-save product, split at bit 19.
// Define MULTI38_2_ACC_EN to accumulate products into a running sum (in_first restarts it).
module multi38_2 #(
  parameter int ACC_W = 46
) (
  input  logic        clk,
  input  logic        rst,
  multi38_2_if.slave  io
);
  localparam int DATA_W = 38;
  localparam int HALF_W = 19;

  function automatic logic signed [ACC_W-1:0] sext_p(input logic [DATA_W-1:0] p);
    logic signed [DATA_W-1:0] ps;
    ps = p;
    return ACC_W'(ps);
  endfunction

  function automatic logic signed [ACC_W-1:0] wrap_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
    return a + b;
  endfunction

  logic                     vld_p1_q, vld_p1_d;
  logic [HALF_W-1:0]        lo_p1_q, lo_p1_d;
  logic                     cy_p1_q, cy_p1_d;
  logic [HALF_W-1:0]        a_hi_p1_q, a_hi_p1_d;
  logic [HALF_W-1:0]        b_hi_p1_q, b_hi_p1_d;
  logic                     vld_p2_q, vld_p2_d;
  logic signed [ACC_W-1:0]  data_p2_q, data_p2_d;
`ifdef MULTI38_2_ACC_EN
  logic                     first_p1_q, first_p1_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
`endif

  logic                     adv1_w, adv2_w, accept_w;
  logic [DATA_W-1:0]        a_w, b_w;
  logic [HALF_W:0]          lo_sum_w;
  logic [HALF_W-1:0]        hi_w;
  logic signed [ACC_W-1:0]  res_w;
  logic                     unused_ok_w;

  // Carry bit 37 falls off the shift; it never contributes to the mod-2^38 product.
  assign unused_ok_w = ^{io.cout3[DATA_W-1], io.in_first};

  assign adv2_w   = !vld_p2_q || io.out_ready;
  assign adv1_w   = !vld_p1_q || adv2_w;
  assign accept_w = io.in_valid && io.in_ready;

  assign io.in_ready  = !rst && adv1_w;
  assign io.out_valid = vld_p2_q;
  assign io.out_data  = data_p2_q;

  // Stage 0 -> 1: low-half add, capture upper operand halves and carry.
  assign a_w      = io.mulout3;
  assign b_w      = {io.cout3[DATA_W-2:0], 1'b0};
  assign lo_sum_w = {1'b0, a_w[HALF_W-1:0]} + {1'b0, b_w[HALF_W-1:0]};

  always_comb begin
    vld_p1_d  = vld_p1_q;
    lo_p1_d   = lo_p1_q;
    cy_p1_d   = cy_p1_q;
    a_hi_p1_d = a_hi_p1_q;
    b_hi_p1_d = b_hi_p1_q;
`ifdef MULTI38_2_ACC_EN
    first_p1_d = first_p1_q;
`endif
    if (adv1_w) begin
      vld_p1_d = accept_w;
    end
    if (accept_w) begin
      lo_p1_d   = lo_sum_w[HALF_W-1:0];
      cy_p1_d   = lo_sum_w[HALF_W];
      a_hi_p1_d = a_w[DATA_W-1:HALF_W];
      b_hi_p1_d = b_w[DATA_W-1:HALF_W];
`ifdef MULTI38_2_ACC_EN
      first_p1_d = io.in_first;
`endif
    end
  end

  // Stage 1 -> 2: upper-half add with the registered carry, then resolve/accumulate.
  assign hi_w = a_hi_p1_q + b_hi_p1_q + HALF_W'(cy_p1_q);

  always_comb begin
`ifdef MULTI38_2_ACC_EN
    res_w = first_p1_q ? sext_p({hi_w, lo_p1_q})
                       : wrap_add(acc_q, sext_p({hi_w, lo_p1_q}));
`else
    res_w = wrap_add('0, sext_p({hi_w, lo_p1_q}));
`endif
  end

  always_comb begin
    vld_p2_d  = vld_p2_q;
    data_p2_d = data_p2_q;
`ifdef MULTI38_2_ACC_EN
    acc_d     = acc_q;
`endif
    if (adv2_w) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        data_p2_d = res_w;
`ifdef MULTI38_2_ACC_EN
        acc_d     = res_w;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
`ifdef MULTI38_2_ACC_EN
      acc_q     <= '0;
`endif
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      data_p2_q <= data_p2_d;
`ifdef MULTI38_2_ACC_EN
      acc_q     <= acc_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    lo_p1_q   <= lo_p1_d;
    cy_p1_q   <= cy_p1_d;
    a_hi_p1_q <= a_hi_p1_d;
    b_hi_p1_q <= b_hi_p1_d;
`ifdef MULTI38_2_ACC_EN
    first_p1_q <= first_p1_d;
`endif
  end
endmodule
